disp_hex_demux: RTL

//  Receive-side counterpart of the 4-digit multiplexed seven-segment driver.
//  - Watches the time-multiplexed an/sseg bus and rebuilds the four hex digits and decimal points.
//  - Used as a display sniffer on the board, and as a self-checking monitor in board-level sims.
//  - Samples each stable digit slot, decodes segments back to hex, and tracks per-digit freshness.

---
 rtl/disp_hex_demux_pkg.sv | 52 +++++
 rtl/seg7_to_hex.sv | 38 +++
 rtl/disp_hex_demux.sv | 122 ++++++++++++
 3 files changed

// File: rtl/disp_hex_demux_pkg.sv
// disp_hex_demux_pkg
//   Shared definitions for the seven-segment bus sniffer: segment codes
//   (active low, bit 6 = a ... bit 0 = g), anode one-hot-low codes, the
//   registered bus type and the anode-to-slot helper.
package disp_hex_demux_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D3   = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;

    // One registered sample of the display bus.
    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
    } bus_t;

    localparam bus_t BUS_IDLE = '{an: AN_NONE, sseg: 8'hFF};

    // Maps an anode pattern to {legal, slot[1:0]}; only one-hot-low is legal.
    function automatic logic [2:0] an_slot(input logic [3:0] an);
        case (an)
            AN_D0:   an_slot = 3'b100;
            AN_D1:   an_slot = 3'b101;
            AN_D2:   an_slot = 3'b110;
            AN_D3:   an_slot = 3'b111;
            default: an_slot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex
//   Combinational inverse of the seven-segment encoder.
//   seg   in  7  active-low segments, bit 6 = a ... bit 0 = g
//   legal out 1  pattern is one of the 16 hex glyphs
//   hex   out 4  decoded value (0 when not legal)
module seg7_to_hex
    import disp_hex_demux_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] hex
);

    always_comb begin
        legal = 1'b1;
        hex   = 4'h0;
        case (seg)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/disp_hex_demux.sv
// disp_hex_demux
//   Sniffs a time-multiplexed 4-digit seven-segment bus and rebuilds the
//   displayed hex digits, decimal points and per-digit freshness.
//   clk, reset       clock; asynchronous active-low reset
//   an[3:0]          digit enables, active low
//   sseg[7:0]        [7]=dp, [6:0]=segments a..g, active low
//   hex3..hex0       last captured value per digit
//   dp_out[3:0]      last captured dp bit per digit
//   valid[3:0]       legal capture and not yet stale
//   seg_err[3:0]     last capture had an illegal segment pattern
//   update           one-cycle pulse, the cycle after a capture
//   update_idx[1:0]  digit of the capture flagged by update
module disp_hex_demux
    import disp_hex_demux_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT_W     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp_out,
    output logic [3:0] valid,
    output logic [3:0] seg_err,
    output logic       update,
    output logic [1:0] update_idx
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    bus_t                                   in_q, prev_q;
    logic [CNT_W-1:0]                       stab_cnt;
    logic [NUM_DIGITS-1:0][3:0]             hex_r;
    logic [NUM_DIGITS-1:0][TIMEOUT_W-1:0]   age;
    logic                                   cap_pend;
    logic [1:0]                             cap_idx;

    logic       same, fire, capture, slot_ok, dec_legal;
    logic [1:0] slot_idx;
    logic [3:0] dec_hex;

    seg7_to_hex u_dec (
        .seg   (in_q.sseg[6:0]),
        .legal (dec_legal),
        .hex   (dec_hex)
    );

    assign same = (in_q == prev_q);
    // Counter reaches STABLE_CYCLES-1 on this edge: the sample has now been
    // seen STABLE_CYCLES times. Saturation above it blocks a re-capture.
    assign fire = same && (stab_cnt == CNT_W'(STABLE_CYCLES - 2));
    assign {slot_ok, slot_idx} = an_slot(in_q.an);
    assign capture = fire && slot_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q     <= BUS_IDLE;
            prev_q   <= BUS_IDLE;
            stab_cnt <= '0;
        end else begin
            in_q   <= '{an: an, sseg: sseg};
            prev_q <= in_q;
            if (!same)
                stab_cnt <= '0;
            else if (stab_cnt != CNT_W'(STABLE_CYCLES))
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Digit registers and age counters. A capture on a digit overrides its
    // timeout on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_r   <= '0;
            dp_out  <= '0;
            valid   <= '0;
            seg_err <= '0;
            age     <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && (slot_idx == 2'(i))) begin
                    if (dec_legal)
                        hex_r[i] <= dec_hex;
                    dp_out[i]  <= in_q.sseg[7];
                    valid[i]   <= dec_legal;
                    seg_err[i] <= !dec_legal;
                    age[i]     <= '0;
                end else if (age[i] != '1) begin
                    age[i] <= age[i] + 1'b1;
                    if (age[i] + 1'b1 == '1)
                        valid[i] <= 1'b0;
                end
            end
        end
    end

    // Outputs land on the capture edge; the update pulse trails by one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_pend   <= 1'b0;
            cap_idx    <= '0;
            update     <= 1'b0;
            update_idx <= '0;
        end else begin
            cap_pend   <= capture;
            cap_idx    <= slot_idx;
            update     <= cap_pend;
            update_idx <= cap_pend ? cap_idx : update_idx;
        end
    end

    assign hex0 = hex_r[0];
    assign hex1 = hex_r[1];
    assign hex2 = hex_r[2];
    assign hex3 = hex_r[3];

endmodule
